// File: rtl/key_debounce_shift.sv
// Debounced keypad front end: accepts a key after a stable press, shifts it into a
// digit history, and optionally auto-repeats while the key stays down.
module key_debounce_shift #(
    parameter int KEY_W           = 4,
    parameter int NUM_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int RELEASE_CYCLES  = 100,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [KEY_W-1:0]            key_code,
    input  logic                        key_pressed,
    output logic [NUM_DIGITS*KEY_W-1:0] digits,
    output logic                        key_strobe,
    output logic                        busy
);

    localparam int DW      = NUM_DIGITS * KEY_W;
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_MAX = (MAX_DR > REPEAT_CYCLES) ? MAX_DR : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HOLD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [KEY_W-1:0]   code_q;
    logic [DW-1:0]      digits_q;
    logic [DW-1:0]      digits_d;
    logic               strobe_q;

    // History with the latched code shifted in as the newest slice; the oldest falls off.
    always_comb begin
        digits_d = (digits_q << KEY_W) | DW'(code_q);
    end

    // Debounce / hold / release FSM with the shared cycle counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            digits_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_pressed) begin
                        code_q  <= key_code;
                        cnt_q   <= '0;
                        state_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_pressed) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (key_code != code_q) begin
                        code_q <= key_code;
                        cnt_q  <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        digits_q <= digits_d;
                        strobe_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!key_pressed) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE_WAIT;
                    end else if (REPEAT_EN != 0) begin
                        // A repeat due right after a strobe waits one cycle, saturated at the limit.
                        if (cnt_q == REP_LAST) begin
                            if (!strobe_q) begin
                                digits_q <= digits_d;
                                strobe_q <= 1'b1;
                                cnt_q    <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (key_pressed) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (cnt_q == REL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign digits     = digits_q;
    assign key_strobe = strobe_q;
    assign busy       = (state_q != IDLE);

endmodule
